xpt_ld16_sequencer: RTL
=======================

Name: xpt_ld16_sequencer

Overview:
- Clocked micro-sequencer for 16-bit register-to-SP transfers: LD SP,HL / LD SP,IX / LD SP,IY.
- Generalises the single-phase combinational LD SP,IX/IY decode into a multi-cycle engine. It owns its own phase counter (XPT), has a configurable pad length, stalls on WAIT, and moves the low and high bytes in separate phases.
- Sits between the opcode/prefix decoder (which raises enable) and the register file / prefix-flag / M1 control logic.

Parameters:
- XPT_W, 5, width of the XPT phase counter output; must satisfy 2^XPT_W > PAD_T+3.
- PAD_T, 2, idle T-states after the start cycle, before the byte transfer; legal range 0..8.
- N_SRC, 3, number of source pairs, one-hot select width (0=HL, 1=IX, 2=IY).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  start request: opcode decoded, prefix resolved.
- src_sel  in  2  source pair: 0 HL, 1 IX, 2 IY, 3 illegal.
- wait_n  in  1  active-low stall.
- XPT  out  XPT_W  phase count since start, saturating.
- busy  out  1  high in every non-IDLE state.
- Select_low  out  N_SRC  one-hot source low-byte select.
- Select_high  out  N_SRC  one-hot source high-byte select.
- Write_SP_low  out  1  SP low-byte write strobe.
- Write_SP_high  out  1  SP high-byte write strobe.
- Reset_XIX  out  1  clear IX-prefix flag (pulse).
- Reset_XIY  out  1  clear IY-prefix flag (pulse).
- Set_CM1  out  1  request next M1 cycle (pulse).
- Reset_XPT  out  1  global phase reset (pulse).
- done  out  1  operation complete (pulse).
- illegal  out  1  src_sel==3 was captured at start; sticky until the next start.

Behaviour:
- Reset: state=IDLE, XPT=0, src register=HL, illegal=0. Every strobe and select output is 0.
- RESET asserted mid-operation: the next cycle is IDLE with the reset values above. No partial strobes are emitted after RESET.
- States: IDLE -> PAD -> LO -> HI -> END -> IDLE. PAD is skipped when PAD_T=0 (IDLE -> LO).
- Start: enable=1 in IDLE latches src_sel and sets XPT=0.
  - Next state is PAD (or LO when PAD_T=0).
  - illegal is set to (src_sel==3); an illegal source executes as HL.
- PAD: lasts exactly PAD_T advancing cycles (internal pad counter); all outputs 0 except busy.
- LO (1 advancing cycle): Select_low[src]=1, Write_SP_low=1.
- HI (1 advancing cycle):
  - Select_high[src]=1, Write_SP_high=1.
  - Reset_XIX=1 if src=IX; Reset_XIY=1 if src=IY; neither for HL.
- END (1 advancing cycle): Set_CM1=1, Reset_XPT=1, done=1.
- Advance condition: wait_n=1. While wait_n=0 in any non-IDLE state:
  - state, pad counter and XPT hold;
  - every strobe/select is forced to 0, so strobes fire only on advancing cycles and exactly once each.
- XPT: increments on each advancing cycle in non-IDLE states. It saturates at 2^XPT_W-1 and returns to 0 on entry to IDLE.
- Total latency, start to done with wait_n=1 throughout: PAD_T+3 cycles after the start cycle (done in cycle PAD_T+3, with the start cycle as cycle 0).
- enable while busy (except END) is ignored; no queueing.
- enable in an advancing END cycle: accepted as a back-to-back start.
  - Next state is PAD/LO with newly latched src; zero bubble.
  - busy stays 1.
- All outputs are registered-state decodes (Moore). No combinational path from enable or src_sel to strobes.
- Outputs are one-hot per phase: at most one of {Write_SP_low, Write_SP_high} per cycle; Select_low and Select_high are never both non-zero.

Decomposition:
- Shared package xpt_pkg:
  - state enum (IDLE, PAD, LO, HI, END);
  - source codes (SRC_HL=0, SRC_IX=1, SRC_IY=2, SRC_ILL=3);
  - function for one-hot source decode.
- One natural sub-module: xpt_phase_counter, a saturating XPT_W counter with hold (wait) and clear inputs; reusable by the other multi-phase op sequencers.
- FSM and output decode stay in the top.

Test Plan:
- PAD_T=2, src_sel=1, wait_n=1: enable pulse at cycle 0 -> Write_SP_low + Select_low=3'b010 at cycle 3; Write_SP_high + Select_high=3'b010 + Reset_XIX at cycle 4; Set_CM1/Reset_XPT/done at cycle 5; XPT=4 at done; busy 1 for cycles 1-5.
- src_sel=2 -> Reset_XIY pulse only, in the HI cycle. src_sel=0 -> neither prefix reset. src_sel=3 -> illegal=1, selects 3'b001 (HL path).
- wait_n=0 for 3 cycles during LO -> LO strobes absent during the stall and asserted once when wait_n=1; done delayed by exactly 3; XPT frozen during the stall.
- enable held high continuously, src 1 then 2 -> second op starts the cycle after END, no bubble; enables during PAD/LO/HI ignored; two done pulses PAD_T+3 apart.
- RESET asserted in HI -> next cycle all outputs 0, XPT=0, busy=0; Reset_XIX never pulses. PAD_T=0 build: done at cycle 3 after start.

Source files
------------

// File: rtl/xpt_pkg.sv
// Shared types for the XPT multi-phase op sequencers: FSM states, source-pair
// codes and the one-hot source decode.
package xpt_pkg;

  localparam int SRC_ONEHOT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAD,
    ST_LO,
    ST_HI,
    ST_END
  } state_e;

  typedef enum logic [1:0] {
    SRC_HL  = 2'd0,
    SRC_IX  = 2'd1,
    SRC_IY  = 2'd2,
    SRC_ILL = 2'd3
  } src_e;

  // The illegal code decodes as HL so a bad prefix still moves a defined pair.
  function automatic logic [SRC_ONEHOT_W-1:0] src_onehot(input src_e s);
    case (s)
      SRC_IX:  return 3'b010;
      SRC_IY:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/xpt_ld16_sequencer_if.sv
// Decoder/register-file side bundle of the LD SP,rr sequencer.
interface xpt_ld16_sequencer_if #(
  parameter int XPT_W = 5,
  parameter int N_SRC = 3
);
  logic             enable;
  logic [1:0]       src_sel;
  logic             wait_n;
  logic [XPT_W-1:0] XPT;
  logic             busy;
  logic [N_SRC-1:0] Select_low;
  logic [N_SRC-1:0] Select_high;
  logic             Write_SP_low;
  logic             Write_SP_high;
  logic             Reset_XIX;
  logic             Reset_XIY;
  logic             Set_CM1;
  logic             Reset_XPT;
  logic             done;
  logic             illegal;

  modport master (
    output enable, src_sel, wait_n,
    input  XPT, busy, Select_low, Select_high, Write_SP_low, Write_SP_high,
           Reset_XIX, Reset_XIY, Set_CM1, Reset_XPT, done, illegal
  );

  modport slave (
    input  enable, src_sel, wait_n,
    output XPT, busy, Select_low, Select_high, Write_SP_low, Write_SP_high,
           Reset_XIX, Reset_XIY, Set_CM1, Reset_XPT, done, illegal
  );
endinterface

// File: rtl/xpt_phase_counter.sv
// Saturating phase counter with hold and clear; shared by the multi-phase
// op sequencers.
module xpt_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (advance && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/xpt_ld16_sequencer.sv
// Multi-cycle LD SP,HL/IX/IY engine: pad, low byte, high byte, end, with WAIT
// stalls and back-to-back starts from END.
module xpt_ld16_sequencer
  import xpt_pkg::*;
#(
  parameter int XPT_W = 5,
  parameter int PAD_T = 2,
  parameter int N_SRC = 3
) (
  input logic                  CLK,
  input logic                  RESET,
  xpt_ld16_sequencer_if.slave  bus
);

  localparam int PAD_CW = 4;
  localparam logic [PAD_CW-1:0] PAD_LAST = PAD_CW'((PAD_T > 0) ? PAD_T - 1 : 0);
  localparam state_e FIRST_STATE = (PAD_T == 0) ? ST_LO : ST_PAD;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic              illegal_q, illegal_d;
  logic [PAD_CW-1:0] pad_q, pad_d;
  logic              start;
  logic              xpt_clear;
  logic              strobe_en;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    illegal_d = illegal_q;
    pad_d     = pad_q;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: start = bus.enable;
      ST_PAD: begin
        if (bus.wait_n) begin
          if (pad_q == PAD_LAST) state_d = ST_LO;
          else                   pad_d   = pad_q + PAD_CW'(1);
        end
      end
      ST_LO:  if (bus.wait_n) state_d = ST_HI;
      ST_HI:  if (bus.wait_n) state_d = ST_END;
      ST_END: begin
        if (bus.wait_n) begin
          state_d = ST_IDLE;
          start   = bus.enable;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d   = FIRST_STATE;
      pad_d     = '0;
      illegal_d = (bus.src_sel == SRC_ILL);
      src_d     = (bus.src_sel == SRC_ILL) ? SRC_HL : src_e'(bus.src_sel);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_HL;
      illegal_q <= 1'b0;
      pad_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      illegal_q <= illegal_d;
      pad_q     <= pad_d;
    end
  end

  // XPT is pinned to zero in IDLE and restarts on leaving END, whether to IDLE or a new op.
  assign xpt_clear = (state_q == ST_IDLE) || ((state_q == ST_END) && bus.wait_n);

  xpt_phase_counter #(.W(XPT_W)) u_phase (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (xpt_clear),
    .advance (bus.wait_n),
    .count   (bus.XPT)
  );

  // Strobes only on advancing cycles; a reset cycle never lets a half-done op strobe.
  assign strobe_en = bus.wait_n && !RESET;

  always_comb begin
    bus.busy          = (state_q != ST_IDLE);
    bus.illegal       = illegal_q;
    bus.Select_low    = '0;
    bus.Select_high   = '0;
    bus.Write_SP_low  = 1'b0;
    bus.Write_SP_high = 1'b0;
    bus.Reset_XIX     = 1'b0;
    bus.Reset_XIY     = 1'b0;
    bus.Set_CM1       = 1'b0;
    bus.Reset_XPT     = 1'b0;
    bus.done          = 1'b0;
    if (strobe_en) begin
      case (state_q)
        ST_LO: begin
          bus.Select_low   = src_onehot(src_q);
          bus.Write_SP_low = 1'b1;
        end
        ST_HI: begin
          bus.Select_high   = src_onehot(src_q);
          bus.Write_SP_high = 1'b1;
          bus.Reset_XIX     = (src_q == SRC_IX);
          bus.Reset_XIY     = (src_q == SRC_IY);
        end
        ST_END: begin
          bus.Set_CM1   = 1'b1;
          bus.Reset_XPT = 1'b1;
          bus.done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
